// File: rtl/rng_cmd_ctrl.sv
// Command sequencer for the 4-digit random-number core: key sync/debounce, arbitration,
// history fill/pointer tracking and roll lockout. Optional auto-repeat: RNG_CTRL_AUTOREPEAT_EN.
module rng_cmd_ctrl #(
    parameter int DEB_CYCLES    = 16,
    parameter int HIST_DEPTH    = 13,
    parameter int BUSY_WAIT     = 4,
    parameter int REPEAT_CYCLES = 256
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_start,
    input  logic       i_key_prev,
    input  logic       i_key_next,
    input  logic       i_busy,
    output logic       o_start,
    output logic       o_prev,
    output logic       o_next,
    output logic       o_err,
    output logic [1:0] o_state,
    output logic [3:0] o_fill,
    output logic [3:0] o_ptr
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int WW = $clog2(BUSY_WAIT + 1);

    generate
        if (DEB_CYCLES < 2 || HIST_DEPTH < 1 || HIST_DEPTH > 15 || BUSY_WAIT < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
            $error("rng_cmd_ctrl: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t          state;
    logic            busy_seen;
    logic [WW-1:0]   wait_cnt;
    logic [3:0]      fill;
    logic [3:0]      ptr;

    // Key vectors are ordered {next, prev, start}; bit 0 has the highest priority.
    logic [2:0]          keys_raw;
    logic [2:0]          sync1;
    logic [2:0]          sync2;
    logic [2:0]          stable;
    logic [2:0]          stable_d;
    logic [2:0][DW-1:0]  deb_cnt;
    logic [2:0]          press;
    logic [2:0]          ev;
    logic                ev_start;
    logic                ev_prev;
    logic                ev_next;

    assign keys_raw = {i_key_next, i_key_prev, i_key_start};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= keys_raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == stable[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DW'(DEB_CYCLES - 1)) begin
                    deb_cnt[k] <= '0;
                    stable[k]  <= sync2[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign press = stable & ~stable_d;

`ifdef RNG_CTRL_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic                idle;
    logic [1:0][RW-1:0]  rep_cnt;
    logic [1:0]          rep_ev;

    assign idle = (state == ST_IDLE);

    // Timer runs only while the key is held in IDLE, so release or any state change restarts it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rep_cnt <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!(stable[k+1] && idle)) begin
                    rep_cnt[k] <= '0;
                end else if (rep_cnt[k] == RW'(REPEAT_CYCLES)) begin
                    rep_cnt[k] <= RW'(1);
                end else begin
                    rep_cnt[k] <= rep_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rep_ev = '0;
        for (int k = 0; k < 2; k++) begin
            rep_ev[k] = stable[k+1] && idle && (rep_cnt[k] == RW'(REPEAT_CYCLES));
        end
    end

    assign ev = press | {rep_ev, 1'b0};
`else
    assign ev = press;
`endif

    assign ev_start = ev[0];
    assign ev_prev  = ev[1] & ~ev[0];
    assign ev_next  = ev[2] & ~ev[1] & ~ev[0];

    // Busy handshake: after o_start the core must raise i_busy within BUSY_WAIT cycles;
    // the following fall of i_busy marks the roll as finished.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_start   <= 1'b0;
            o_prev    <= 1'b0;
            o_next    <= 1'b0;
            o_err     <= 1'b0;
            busy_seen <= 1'b0;
            wait_cnt  <= '0;
            fill      <= '0;
            ptr       <= '0;
        end else begin
            o_start <= 1'b0;
            o_prev  <= 1'b0;
            o_next  <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ev_start) begin
                        o_start   <= 1'b1;
                        ptr       <= '0;
                        if (fill < 4'(HIST_DEPTH)) fill <= fill + 4'd1;
                        busy_seen <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= ST_ROLL;
                    end else if (ev_prev) begin
                        if (({1'b0, ptr} + 5'd1) < {1'b0, fill}) begin
                            o_prev <= 1'b1;
                            ptr    <= ptr + 4'd1;
                        end
                    end else if (ev_next && ptr != 4'd0) begin
                        o_next <= 1'b1;
                        ptr    <= ptr - 4'd1;
                    end
                end
                ST_ROLL: begin
                    if (ev_start) begin
                        o_start <= 1'b1;
                        state   <= ST_STOP;
                    end else if (busy_seen && !i_busy) begin
                        state <= ST_IDLE;
                    end else if (i_busy) begin
                        busy_seen <= 1'b1;
                    end else if (wait_cnt == WW'(BUSY_WAIT - 1)) begin
                        o_err <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (!i_busy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_state = state;
    assign o_fill  = fill;
    assign o_ptr   = ptr;

endmodule

// File: tb/tb_rng_cmd_ctrl.sv
// Directed and randomized checks of rng_cmd_ctrl against a press-level model of fill/ptr.
module tb_rng_cmd_ctrl;

    localparam int DEB  = 4;
    localparam int HIST = 3;
    localparam int BW   = 4;
    localparam int REP  = 8;
    localparam int LAT  = DEB + 3;

    logic       clk;
    logic       rst_n;
    logic       key_start;
    logic       key_prev;
    logic       key_next;
    logic       busy;
    logic       o_start;
    logic       o_prev;
    logic       o_next;
    logic       o_err;
    logic [1:0] o_state;
    logic [3:0] o_fill;
    logic [3:0] o_ptr;

    rng_cmd_ctrl #(
        .DEB_CYCLES   (DEB),
        .HIST_DEPTH   (HIST),
        .BUSY_WAIT    (BW),
        .REPEAT_CYCLES(REP)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_key_start(key_start),
        .i_key_prev (key_prev),
        .i_key_next (key_next),
        .i_busy     (busy),
        .o_start    (o_start),
        .o_prev     (o_prev),
        .o_next     (o_next),
        .o_err      (o_err),
        .o_state    (o_state),
        .o_fill     (o_fill),
        .o_ptr      (o_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor
    int n_start = 0, n_prev = 0, n_next = 0, n_err = 0, mex_bad = 0;
    int last_start = 0, last_prev = 0, last_next = 0, last_err = 0;
    always @(negedge clk) begin
        if (o_start) begin n_start++; last_start = cyc; end
        if (o_prev)  begin n_prev++;  last_prev  = cyc; end
        if (o_next)  begin n_next++;  last_next  = cyc; end
        if (o_err)   begin n_err++;   last_err   = cyc; end
        if (int'(o_start) + int'(o_prev) + int'(o_next) > 1) mex_bad++;
    end

    // scoreboard
    int n_checks = 0, n_pass = 0, n_fail = 0;
    int m_fill = 0, m_ptr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_start();
        m_ptr = 0;
        if (m_fill < HIST) m_fill++;
    endfunction

    function automatic bit model_prev();
        if (m_ptr + 1 < m_fill) begin m_ptr++; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic bit model_next();
        if (m_ptr > 0) begin m_ptr--; return 1'b1; end
        return 1'b0;
    endfunction

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic roll_op(input bit with_prev, input int hold, input int blen);
        int t, s0, p0;
        s0 = n_start; p0 = n_prev; t = cyc;
        key_start = 1'b1; key_prev = with_prev;
        repeat (hold) tick();
        key_start = 1'b0; key_prev = 1'b0;
        repeat (LAT - hold) tick();
        busy = 1'b1;
        repeat (blen) tick();
        busy = 1'b0;
        repeat (12) tick();
        model_start();
        check("roll_start_cnt", n_start - s0, 1);
        check("roll_latency", last_start - t, LAT);
        check("roll_prev_lost", n_prev - p0, 0);
        check("roll_fill", o_fill, m_fill);
        check("roll_ptr", o_ptr, m_ptr);
        check("roll_state", o_state, 0);
    endtask

    task automatic key_op(input int which, input int hold);
        int t, p0, q0;
        bit exp;
        p0 = n_prev; q0 = n_next; t = cyc;
        if (which == 1) key_prev = 1'b1; else key_next = 1'b1;
        repeat (hold) tick();
        key_prev = 1'b0; key_next = 1'b0;
        repeat (16 - hold) tick();
        exp = (which == 1) ? model_prev() : model_next();
        if (which == 1) begin
            check("prev_cnt", n_prev - p0, int'(exp));
            check("prev_other", n_next - q0, 0);
            if (exp) check("prev_latency", last_prev - t, LAT);
        end else begin
            check("next_cnt", n_next - q0, int'(exp));
            check("next_other", n_prev - p0, 0);
            if (exp) check("next_latency", last_next - t, LAT);
        end
        check("key_ptr", o_ptr, m_ptr);
        check("key_fill", o_fill, m_fill);
    endtask

    task automatic glitch_op(input int which, input int hold);
        int s0, p0, q0;
        s0 = n_start; p0 = n_prev; q0 = n_next;
        case (which)
            0: key_start = 1'b1;
            1: key_prev  = 1'b1;
            default: key_next = 1'b1;
        endcase
        repeat (hold) tick();
        key_start = 1'b0; key_prev = 1'b0; key_next = 1'b0;
        repeat (14) tick();
        check("glitch_pulses", (n_start - s0) + (n_prev - p0) + (n_next - q0), 0);
        check("glitch_ptr", o_ptr, m_ptr);
    endtask

    int t0, s0, p0, e0, op, n_rep, acc, last_k;

    initial begin
        rst_n = 1'b0; key_start = 1'b0; key_prev = 1'b0; key_next = 1'b0; busy = 1'b0;
        repeat (3) tick();
        check("rst_state", o_state, 0);
        check("rst_fill", o_fill, 0);
        check("rst_ptr", o_ptr, 0);
        check("rst_pulses", {o_start, o_prev, o_next, o_err}, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // reset in the middle of a roll
        key_start = 1'b1;
        repeat (5) tick();
        key_start = 1'b0;
        repeat (LAT - 5) tick();
        busy = 1'b1;
        repeat (3) tick();
        check("midroll_state", o_state, 1);
        check("midroll_fill", o_fill, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midroll_rst_state", o_state, 0);
        check("midroll_rst_fill", o_fill, 0);
        check("midroll_rst_out", {o_start, o_prev, o_next, o_err, o_ptr}, 0);
        busy = 1'b0;
        tick();
        rst_n = 1'b1;
        m_fill = 0; m_ptr = 0;
        repeat (12) tick();

        // long clean start press, core busy for 10 cycles
        s0 = n_start; t0 = cyc;
        key_start = 1'b1;
        repeat (LAT) tick();
        busy = 1'b1;
        repeat (10) tick();
        check("long_state_roll", o_state, 1);
        busy = 1'b0;
        repeat (2) tick();
        check("long_state_idle", o_state, 0);
        repeat (40 - LAT - 12) tick();
        key_start = 1'b0;
        repeat (12) tick();
        model_start();
        check("long_start_cnt", n_start - s0, 1);
        check("long_latency", last_start - t0, LAT);
        check("long_fill", o_fill, m_fill);

        // short start glitch
        glitch_op(0, DEB - 1);

        // start and prev pressed together: start wins
        roll_op(1'b1, 5, 4);

        // saturate history
        roll_op(1'b0, 5, 3);
        roll_op(1'b0, 6, 5);
        check("fill_saturated", o_fill, HIST);

        // browse past both ends
        repeat (3) key_op(1, 5);
        check("browse_ptr_top", o_ptr, HIST - 1);
        repeat (3) key_op(2, 5);
        check("browse_ptr_bottom", o_ptr, 0);

        // abort during roll, prev ignored while stopping
        s0 = n_start;
        key_start = 1'b1;
        repeat (5) tick();
        key_start = 1'b0;
        repeat (LAT - 5) tick();
        busy = 1'b1;
        model_start();
        repeat (12) tick();
        check("abort_roll_state", o_state, 1);
        key_start = 1'b1;
        repeat (5) tick();
        key_start = 1'b0;
        repeat (LAT - 5) tick();
        check("abort_pulse", o_start, 1);
        check("abort_state", o_state, 2);
        p0 = n_prev;
        key_prev = 1'b1;
        repeat (5) tick();
        key_prev = 1'b0;
        repeat (12) tick();
        check("stop_prev_dropped", n_prev - p0, 0);
        check("stop_state_held", o_state, 2);
        busy = 1'b0;
        repeat (2) tick();
        check("stop_state_idle", o_state, 0);
        check("abort_start_cnt", n_start - s0, 2);
        check("abort_fill", o_fill, m_fill);

        // busy never rises
        s0 = n_start; e0 = n_err;
        key_start = 1'b1;
        repeat (5) tick();
        key_start = 1'b0;
        repeat (14) tick();
        model_start();
        check("err_start_cnt", n_start - s0, 1);
        check("err_cnt", n_err - e0, 1);
        check("err_delay", last_err - last_start, BW);
        check("err_state", o_state, 0);

        // randomized operation mix
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: roll_op(1'($urandom_range(0, 1)), $urandom_range(DEB, LAT), $urandom_range(1, 8));
                1, 2: key_op(1, $urandom_range(DEB, LAT));
                3: key_op(2, $urandom_range(DEB, LAT));
                default: glitch_op($urandom_range(0, 2), $urandom_range(1, DEB - 1));
            endcase
        end

`ifdef RNG_CTRL_AUTOREPEAT_EN
        // held prev repeats every REP cycles after the press, bounded by history
        roll_op(1'b0, 5, 2);
        p0 = n_prev; t0 = cyc;
        key_prev = 1'b1;
        repeat (30) tick();
        key_prev = 1'b0;
        repeat (14) tick();
        n_rep = (30 - 1) / REP + 1;
        acc = 0; last_k = 0;
        for (int k = 0; k < n_rep; k++) begin
            if (model_prev()) begin acc++; last_k = k; end
        end
        check("rep_cnt", n_prev - p0, acc);
        check("rep_last", last_prev - t0, LAT + last_k * REP);
        check("rep_ptr", o_ptr, m_ptr);
`endif

        check("mutual_exclusion", mex_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
